// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode and FSM state encodings, instruction field positions,
// and the combinational opcode classifier used by the decode FSM.
package decode_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_SHL  = 4'h6,
      OP_SHR  = 4'h7,
      OP_LDI  = 4'h8,
      OP_ADDI = 4'h9,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int RS1_HI = 7;
   localparam int RS1_LO = 4;
   localparam int RS2_HI = 3;
   localparam int RS2_LO = 0;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   typedef struct packed {
      logic writes_rd;
      logic uses_imm;
      logic illegal;
   } dec_t;

   // Codes A..E are unassigned; everything from ADD through ADDI writes rd.
   function automatic dec_t decode_op(input logic [3:0] op);
      dec_t d;
      d.writes_rd = (op >= OP_ADD) && (op <= OP_ADDI);
      d.uses_imm  = (op == OP_LDI) || (op == OP_ADDI);
      d.illegal   = (op > OP_ADDI) && (op < OP_HALT);
      return d;
   endfunction

endpackage

// File: rtl/decode_unit_if.sv
// Fetch/decode/issue bundle between the decode unit (slave) and its surroundings (master).
interface decode_unit_if #(parameter int CNT_W = 16) ();
   logic             start;
   logic             en_pc;
   logic [15:0]      instruction;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       opcode;
   logic [3:0]       rd;
   logic [3:0]       rs1;
   logic [3:0]       rs2;
   logic [7:0]       imm8;
   logic             uses_imm;
   logic             writes_rd;
   logic             halted;
   logic             illegal;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output start, instruction, out_ready,
      input  en_pc, out_valid, opcode, rd, rs1, rs2, imm8,
             uses_imm, writes_rd, halted, illegal, instr_count
   );

   modport slave (
      input  start, instruction, out_ready,
      output en_pc, out_valid, opcode, rd, rs1, rs2, imm8,
             uses_imm, writes_rd, halted, illegal, instr_count
   );
endinterface

// File: rtl/decode_unit.sv
// Instruction decode FSM: fetch -> decode -> issue with valid/ready hold in ISSUE; first
// out_valid three cycles after start, one instruction per three cycles at full throughput.
module decode_unit
   import decode_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   decode_unit_if.slave bus
);

   state_e           state;
   state_e           state_nxt;
   logic [3:0]       op_in;
   dec_t             dec_in;
   logic             count_inc;

   logic [3:0]       opcode_q;
   logic [3:0]       rd_q;
   logic [3:0]       rs1_q;
   logic [3:0]       rs2_q;
   logic [7:0]       imm8_q;
   logic             uses_imm_q;
   logic             writes_rd_q;
   logic             halted_q;
   logic             illegal_q;
   logic [CNT_W-1:0] count_q;

   assign op_in  = bus.instruction[OPC_HI:OPC_LO];
   assign dec_in = decode_op(op_in);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (bus.start) state_nxt = ST_FETCH;
         ST_FETCH:  state_nxt = ST_DECODE;
         ST_DECODE: begin
            if (dec_in.illegal || op_in == OP_HALT) state_nxt = ST_HALT;
            else if (op_in == OP_NOP)               state_nxt = ST_FETCH;
            else                                    state_nxt = ST_ISSUE;
         end
         ST_ISSUE:  if (bus.out_ready) state_nxt = ST_FETCH;
         ST_HALT:   state_nxt = ST_HALT;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode_q    <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm8_q      <= '0;
         uses_imm_q  <= 1'b0;
         writes_rd_q <= 1'b0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (state == ST_DECODE) begin
         opcode_q    <= op_in;
         rd_q        <= bus.instruction[RD_HI:RD_LO];
         rs1_q       <= bus.instruction[RS1_HI:RS1_LO];
         rs2_q       <= bus.instruction[RS2_HI:RS2_LO];
         imm8_q      <= bus.instruction[IMM_HI:IMM_LO];
         uses_imm_q  <= dec_in.uses_imm;
         writes_rd_q <= dec_in.writes_rd;
         if (op_in == OP_HALT) halted_q  <= 1'b1;
         if (dec_in.illegal)   illegal_q <= 1'b1;
      end
   end

   // Retirement: issue handshake, NOP dropping out of decode, or HALT entry; illegal never retires.
   assign count_inc = (state == ST_ISSUE && bus.out_ready) ||
                      (state == ST_DECODE && (op_in == OP_NOP || op_in == OP_HALT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                       count_q <= '0;
      else if (count_inc && count_q != {CNT_W{1'b1}})  count_q <= count_q + CNT_W'(1);
   end

   assign bus.en_pc       = (state == ST_FETCH);
   assign bus.out_valid   = (state == ST_ISSUE);
   assign bus.opcode      = opcode_q;
   assign bus.rd          = rd_q;
   assign bus.rs1         = rs1_q;
   assign bus.rs2         = rs2_q;
   assign bus.imm8        = imm8_q;
   assign bus.uses_imm    = uses_imm_q;
   assign bus.writes_rd   = writes_rd_q;
   assign bus.halted      = halted_q;
   assign bus.illegal     = illegal_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: vector table for the issue path, hand sequences for illegal,
// HALT, reset-in-ISSUE and counter saturation on a narrow-counter instance.
module tb_decode_unit;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   count_exp = 0;
   logic prev_en_pc = 1'b0;

   always #5 clk = ~clk;

   decode_unit_if #(.CNT_W(16)) bus ();
   decode_unit_if #(.CNT_W(2))  bus2 ();

   decode_unit #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
   decode_unit #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

   typedef struct {
      logic [15:0] instr;
      int          hold;
      logic        issue;
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [7:0]  imm8;
      logic        uses_imm;
      logic        writes_rd;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // en_pc must never be high in two consecutive cycles.
   always @(negedge clk) begin
      if (bus.en_pc === 1'b1) begin
         checks++;
         if (prev_en_pc) begin
            errors++;
            $display("FAIL en_pc_back_to_back: got 1 expected 0");
         end
      end
      prev_en_pc = (bus.en_pc === 1'b1);
   end

   task automatic wait_en_pc();
      int n = 0;
      while (bus.en_pc !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      chk("en_pc_seen", {31'b0, bus.en_pc}, 32'd1);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Entered at the FETCH negedge; leaves at the negedge after DECODE has been sampled.
   task automatic fetch_decode(input logic [15:0] instr);
      bus.instruction = 16'hEEEE;
      tick();
      bus.instruction = instr;
      chk("decode_en_pc", {31'b0, bus.en_pc}, 32'd0);
      chk("decode_out_valid", {31'b0, bus.out_valid}, 32'd0);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_en_pc", {31'b0, bus.en_pc}, 32'd0);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_fields", {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm8}, 32'd0);
      chk("rst_flags", {28'b0, bus.uses_imm, bus.writes_rd, bus.halted, bus.illegal}, 32'd0);
      chk("rst_count", {16'b0, bus.instr_count}, 32'd0);
      tick();
      reset = 1'b0;
      count_exp = 0;
   endtask

   initial begin
      vecs[0] = '{16'h1123, 0, 1'b1, 4'h1, 4'h1, 4'h2, 4'h3, 8'h23, 1'b0, 1'b1};
      vecs[1] = '{16'h84A5, 5, 1'b1, 4'h8, 4'h4, 4'hA, 4'h5, 8'hA5, 1'b1, 1'b1};
      vecs[2] = '{16'h2F0E, 1, 1'b1, 4'h2, 4'hF, 4'h0, 4'hE, 8'h0E, 1'b0, 1'b1};
      vecs[3] = '{16'h7456, 0, 1'b1, 4'h7, 4'h4, 4'h5, 4'h6, 8'h56, 1'b0, 1'b1};
      vecs[4] = '{16'h0000, 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{16'h9127, 0, 1'b1, 4'h9, 4'h1, 4'h2, 4'h7, 8'h27, 1'b1, 1'b1};

      reset = 1'b1;
      bus.start = 1'b0;
      bus.instruction = 16'h0000;
      bus.out_ready = 1'b1;
      bus2.start = 1'b0;
      bus2.instruction = 16'h1123;
      bus2.out_ready = 1'b1;
      tick();
      do_reset();

      // No fetch without start.
      repeat (4) tick();
      chk("idle_no_fetch", {31'b0, bus.en_pc}, 32'd0);

      // start at cycle 0 -> en_pc at cycle 1 -> out_valid at cycle 3.
      pulse_start();
      chk("latency_en_pc_c1", {31'b0, bus.en_pc}, 32'd1);

      for (int i = 0; i < 6; i++) begin
         wait_en_pc();
         fetch_decode(vecs[i].instr);
         bus.out_ready = (vecs[i].hold == 0);
         #1;
         if (vecs[i].issue) begin
            chk($sformatf("v%0d_out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("v%0d_fields", i), {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm8},
                {vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm8});
            chk($sformatf("v%0d_flags", i), {30'b0, bus.uses_imm, bus.writes_rd},
                {30'b0, vecs[i].uses_imm, vecs[i].writes_rd});
            chk($sformatf("v%0d_count_pre", i), {16'b0, bus.instr_count}, count_exp);
            for (int h = 1; h < vecs[i].hold; h++) begin
               tick();
               chk($sformatf("v%0d_hold_valid", i), {30'b0, bus.out_valid, bus.en_pc}, 32'd2);
               chk($sformatf("v%0d_hold_fields", i), {bus.opcode, bus.imm8, bus.uses_imm},
                   {vecs[i].op, vecs[i].imm8, vecs[i].uses_imm});
            end
            bus.out_ready = 1'b1;
            tick();
            count_exp++;
            chk($sformatf("v%0d_refetch", i), {30'b0, bus.en_pc, bus.out_valid}, 32'd2);
            chk($sformatf("v%0d_count", i), {16'b0, bus.instr_count}, count_exp);
         end else begin
            count_exp++;
            chk($sformatf("v%0d_nop_refetch", i), {30'b0, bus.en_pc, bus.out_valid}, 32'd2);
            chk($sformatf("v%0d_nop_fields", i), {24'b0, bus.opcode, 2'b0, bus.uses_imm, bus.writes_rd}, 32'd0);
            chk($sformatf("v%0d_nop_count", i), {16'b0, bus.instr_count}, count_exp);
         end
      end

      // Illegal opcode: stops the machine without retiring or presenting anything.
      wait_en_pc();
      fetch_decode(16'hB000);
      chk("ill_flags", {30'b0, bus.illegal, bus.halted}, 32'd2);
      chk("ill_no_valid", {30'b0, bus.out_valid, bus.en_pc}, 32'd0);
      chk("ill_count", {16'b0, bus.instr_count}, count_exp);
      pulse_start();
      repeat (3) tick();
      chk("ill_stuck", {30'b0, bus.out_valid, bus.en_pc}, 32'd0);
      chk("ill_count_after", {16'b0, bus.instr_count}, count_exp);
      do_reset();

      // HALT retires once and ignores start.
      pulse_start();
      wait_en_pc();
      fetch_decode(16'hF000);
      chk("halt_flags", {30'b0, bus.halted, bus.illegal}, 32'd2);
      chk("halt_count", {16'b0, bus.instr_count}, 32'd1);
      pulse_start();
      repeat (3) tick();
      chk("halt_stuck", {29'b0, bus.en_pc, bus.out_valid, bus.halted}, 32'd1);
      chk("halt_count_after", {16'b0, bus.instr_count}, 32'd1);
      do_reset();

      // Reset while presenting: out_valid drops immediately, no retirement.
      pulse_start();
      wait_en_pc();
      bus.out_ready = 1'b0;
      fetch_decode(16'h1123);
      chk("rin_valid", {31'b0, bus.out_valid}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rin_valid_drop", {31'b0, bus.out_valid}, 32'd0);
      chk("rin_fields", {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm8}, 32'd0);
      chk("rin_count", {16'b0, bus.instr_count}, 32'd0);
      tick();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("rin_no_fetch", {30'b0, bus.en_pc, bus.out_valid}, 32'd0);
      chk("rin_count_after", {16'b0, bus.instr_count}, 32'd0);

      // Narrow counter saturates at 3 after more than three retirements.
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      repeat (20) tick();
      chk("sat_count", {30'b0, bus2.instr_count}, 32'd3);
      chk("sat_flags", {30'b0, bus2.halted, bus2.illegal}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins fetching from IDLE.
REQ-005 en_pc  output  1  fetch-stage enable (advances PC and loads next instruction).
REQ-006 instruction  input  16  word from fetch stage, valid the cycle after en_pc=1.
REQ-007 out_valid  output  1  decoded instruction presented downstream.
REQ-008 out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-009 opcode  output  4  instruction[15:12].
REQ-010 rd  output  4  instruction[11:8].
REQ-011 rs1  output  4  instruction[7:4].
REQ-012 rs2  output  4  instruction[3:0]; also the imm4 source.
REQ-013 imm8  output  8  instruction[7:0], zero-extended use downstream.
REQ-014 uses_imm  output  1  operand B is an immediate (LDI, ADDI).
REQ-015 writes_rd  output  1  instruction writes rd.
REQ-016 halted  output  1  sticky; HALT opcode retired.
REQ-017 illegal  output  1  sticky; illegal opcode decoded.
REQ-018 instr_count  output  CNT_W  instructions retired since reset.

Function
REQ-019 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 LDI, 9 ADDI, A-E illegal, F HALT.
REQ-020 writes_rd = 1 for opcodes 1-9, else 0; uses_imm = 1 for 8 and 9 only.
REQ-021 FSM states: IDLE, FETCH, DECODE, ISSUE, HALT.
REQ-022 IDLE: en_pc=0; start=1 -> FETCH; start ignored in every other state.
REQ-023 FETCH: en_pc=1 for exactly this one cycle -> DECODE.
REQ-024 DECODE: sample instruction, register all field outputs and flags; next state by opcode: 1-9 -> ISSUE; 0 -> FETCH; F -> HALT; A-E -> HALT with illegal=1.
REQ-025 ISSUE: out_valid=1, fields held stable; out_ready=1 -> FETCH next cycle, else stay.
REQ-026 out_valid is high only in ISSUE; fields change only on the DECODE edge.
REQ-027 Latency: start at cycle 0 -> en_pc cycle 1 -> out_valid cycle 3; throughput one instruction per 3 cycles with out_ready held 1.
REQ-028 instr_count increments by 1 on each ISSUE handshake, on each NOP leaving DECODE, and on HALT entry; saturates at all-ones.
REQ-029 HALT: en_pc=0, out_valid=0, halted=1; exit only via reset.
REQ-030 Illegal opcode does not increment instr_count and is never presented downstream.
REQ-031 en_pc never asserted in two consecutive cycles.

Reset
REQ-032 reset=1 forces, asynchronously, state=IDLE and every output to 0 (en_pc, out_valid, fields, flags, instr_count).
REQ-033 Reset mid-ISSUE drops out_valid immediately without a handshake; count is not incremented.
REQ-034 After reset deassertion, no fetch occurs until start.

Structure
REQ-035 Shared package decode_pkg holds the opcode enum, FSM state enum, field bit-position constants, and the combinational decode function (writes_rd, uses_imm, illegal).
REQ-036 No sub-module; single module with one FSM, one output register bank, one counter.

Verification
REQ-037 reset, start, instruction 0x1123 (ADD), out_ready=1 -> en_pc cycle 1, out_valid cycle 3 with opcode=1, rd=1, rs1=2, rs2=3, writes_rd=1, uses_imm=0; instr_count=1.
REQ-038 LDI 0x84A5 with out_ready=0 for 5 cycles -> out_valid held, imm8=0xA5, uses_imm=1, no en_pc until ready; then FETCH.
REQ-039 Sequence NOP 0x0000, ADDI 0x9127 -> NOP yields no out_valid, en_pc reasserts 2 cycles later; ADDI issued with rs2=7; instr_count=2.
REQ-040 Opcode 0xB000 -> illegal=1, halted=0, no out_valid, en_pc stays 0, instr_count unchanged.
REQ-041 HALT 0xF000 -> halted=1, count +1, start pulses ignored; reset in ISSUE clears all outputs same cycle.
REQ-042 CNT_W=2, 5 ADDs -> instr_count saturates at 3.
